// File: rtl/ldpc_fetch.sv
// ldpc_fetch: fetches LDPC codewords from the byte deinterleaver frame memory
// one at a time (ldpc_req/ldpc_fin handshake), packs PACK soft values per word
// and streams them to the LDPC decoder input buffer with sop/eop framing.
// Optional build macro: LDPC_FETCH_SAT_EN -- clips the most negative soft
// value to the symmetric range before packing.
module ldpc_fetch #(
  parameter int WID    = 6,
  parameter int PACK   = 4,
  parameter int CW_LEN = 9216
) (
  input  logic                clk6,
  input  logic                rst,
  input  logic                bidin_rdy,
  input  logic                bidin_ena_out,
  input  logic [WID-1:0]      bidin_dout,
  input  logic [5:0]          cw_num,
  input  logic                dec_rdy,
  output logic                ldpc_req,
  output logic                ldpc_fin,
  output logic                dec_vld,
  output logic [WID*PACK-1:0] dec_data,
  output logic                dec_sop,
  output logic                dec_eop,
  output logic                ovf_err
);

  localparam int NWORD = CW_LEN / PACK;
  localparam int SW    = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
  localparam int LW    = (PACK > 1)   ? $clog2(PACK)   : 1;
  localparam int WW    = (NWORD > 1)  ? $clog2(NWORD)  : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t              state;
  logic [SW-1:0]       smp_cnt;
  logic [LW-1:0]       lane_cnt;
  logic [WW-1:0]       word_cnt;
  logic [5:0]          cw_cnt;
  logic [5:0]          cw_lat;
  logic [WID*PACK-1:0] pack_q;
  logic [WID-1:0]      smp;
  logic [WID*PACK-1:0] word_nxt;
  logic                last_smp;
  logic                word_done;

`ifdef LDPC_FETCH_SAT_EN
  localparam logic [WID-1:0] MOST_NEG = {1'b1, {(WID-1){1'b0}}};
  localparam logic [WID-1:0] SAT_NEG  = {1'b1, {(WID-2){1'b0}}, 1'b1};

  // Clip the asymmetric most-negative code so the decoder sees a symmetric LLR range
  always_comb begin
    smp = bidin_dout;
    if (bidin_dout == MOST_NEG) smp = SAT_NEG;
  end
`else
  // Samples pass through bit-exact
  always_comb begin
    smp = bidin_dout;
  end
`endif

  // Current pack register with the incoming sample merged into its lane
  always_comb begin
    word_nxt = pack_q;
    word_nxt[lane_cnt*WID +: WID] = smp;
  end

  assign last_smp  = (smp_cnt == SW'(CW_LEN - 1));
  assign word_done = (lane_cnt == LW'(PACK - 1));

  // Sticky flag: strobe arriving while not receiving a codeword
  always_ff @(posedge clk6 or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (bidin_ena_out && (state != S_RECV)) begin
      ovf_err <= 1'b1;
    end
  end

  // Fetch FSM, sample packing and registered decoder-side outputs
  always_ff @(posedge clk6 or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      smp_cnt  <= '0;
      lane_cnt <= '0;
      word_cnt <= '0;
      cw_cnt   <= '0;
      cw_lat   <= '0;
      pack_q   <= '0;
      ldpc_req <= 1'b0;
      ldpc_fin <= 1'b0;
      dec_vld  <= 1'b0;
      dec_data <= '0;
      dec_sop  <= 1'b0;
      dec_eop  <= 1'b0;
    end else begin
      ldpc_req <= 1'b0;
      ldpc_fin <= 1'b0;
      dec_vld  <= 1'b0;
      dec_sop  <= 1'b0;
      dec_eop  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bidin_rdy && (cw_num != '0)) begin
            cw_lat <= cw_num;
            cw_cnt <= '0;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (dec_rdy) begin
            ldpc_req <= 1'b1;
            state    <= S_RECV;
          end
        end

        S_RECV: begin
          if (bidin_ena_out) begin
            pack_q <= word_nxt;
            if (word_done) begin
              lane_cnt <= '0;
              dec_vld  <= 1'b1;
              dec_data <= word_nxt;
              dec_sop  <= (word_cnt == '0);
              dec_eop  <= (word_cnt == WW'(NWORD - 1));
              word_cnt <= word_cnt + WW'(1);
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
            end

            if (last_smp) begin
              smp_cnt  <= '0;
              word_cnt <= '0;
              cw_cnt   <= cw_cnt + 6'd1;
              if ((cw_cnt + 6'd1) == cw_lat) state <= S_DONE;
              else                           state <= S_WAIT;
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
        end

        S_DONE: begin
          ldpc_fin <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_fetch.sv
// Directed, table-driven bench for ldpc_fetch with CW_LEN=16, PACK=4, WID=6.
module tb_ldpc_fetch;

  localparam int WID    = 6;
  localparam int PACK   = 4;
  localparam int CW_LEN = 16;

  logic                clk6 = 1'b0;
  logic                rst = 1'b0;
  logic                bidin_rdy = 1'b0;
  logic                bidin_ena_out = 1'b0;
  logic [WID-1:0]      bidin_dout = '0;
  logic [5:0]          cw_num = '0;
  logic                dec_rdy = 1'b0;
  logic                ldpc_req;
  logic                ldpc_fin;
  logic                dec_vld;
  logic [WID*PACK-1:0] dec_data;
  logic                dec_sop;
  logic                dec_eop;
  logic                ovf_err;

  ldpc_fetch #(.WID(WID), .PACK(PACK), .CW_LEN(CW_LEN)) dut (
    .clk6          (clk6),
    .rst           (rst),
    .bidin_rdy     (bidin_rdy),
    .bidin_ena_out (bidin_ena_out),
    .bidin_dout    (bidin_dout),
    .cw_num        (cw_num),
    .dec_rdy       (dec_rdy),
    .ldpc_req      (ldpc_req),
    .ldpc_fin      (ldpc_fin),
    .dec_vld       (dec_vld),
    .dec_data      (dec_data),
    .dec_sop       (dec_sop),
    .dec_eop       (dec_eop),
    .ovf_err       (ovf_err)
  );

  always #5 clk6 = ~clk6;

  int cyc = 0;
  always @(posedge clk6) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] din;
    logic [23:0] exp;
    logic        sop;
    logic        eop;
  } vec_t;

  vec_t tbl [12];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Output log written by the monitor
  logic [23:0] vq_data [$];
  logic        vq_sop [$];
  logic        vq_eop [$];
  int          vq_cyc [$];
  int          req_cnt = 0;
  int          fin_cnt = 0;
  int          both_cnt = 0;
  int          fin_cyc = 0;
  int          eop_cyc = 0;
  int          strobe_cyc [4];

  always @(negedge clk6) begin
    if (ldpc_req) req_cnt++;
    if (ldpc_fin) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (ldpc_req && ldpc_fin) both_cnt++;
    if (dec_vld) begin
      vq_data.push_back(dec_data);
      vq_sop.push_back(dec_sop);
      vq_eop.push_back(dec_eop);
      vq_cyc.push_back(cyc);
      if (dec_eop) eop_cyc = cyc;
    end
  end

  function automatic vec_t mk(input logic [23:0] din, input logic [23:0] exp,
                              input logic sop, input logic eop);
    vec_t v;
    v.din = din;
    v.exp = exp;
    v.sop = sop;
    v.eop = eop;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk6);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_log();
    vq_data.delete();
    vq_sop.delete();
    vq_eop.delete();
    vq_cyc.delete();
    req_cnt = 0;
    fin_cnt = 0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ldpc_req && n < budget);
    chk(name, 32'(ldpc_req), 32'd1);
  endtask

  task automatic wait_fin(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ldpc_fin && n < budget);
    chk(name, 32'(ldpc_fin), 32'd1);
  endtask

  // Stream one codeword (4 table words) with 'gap' idle cycles between strobes
  task automatic send_cw(input int ti, input int gap);
    for (int w = 0; w < 4; w++) begin
      for (int l = 0; l < PACK; l++) begin
        bidin_dout    = tbl[ti+w].din[l*WID +: WID];
        bidin_ena_out = 1'b1;
        if (l == PACK - 1) strobe_cyc[w] = cyc;
        tick();
        bidin_ena_out = 1'b0;
        if (!(w == 3 && l == PACK - 1)) repeat (gap) tick();
      end
    end
  endtask

  task automatic check_words(input string tag, input int ti, input int n);
    chk({tag, "_nwords"}, 32'(vq_data.size()), 32'(n));
    for (int i = 0; i < n && i < vq_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(vq_data[i]), 32'(tbl[ti+i].exp));
      chk($sformatf("%s_sop%0d", tag, i), 32'(vq_sop[i]), 32'(tbl[ti+i].sop));
      chk($sformatf("%s_eop%0d", tag, i), 32'(vq_eop[i]), 32'(tbl[ti+i].eop));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Codeword with soft values 0..15, used twice per two-codeword frame
    tbl[0] = mk({6'd3, 6'd2, 6'd1, 6'd0},     24'h0C2040, 1'b1, 1'b0);
    tbl[1] = mk({6'd7, 6'd6, 6'd5, 6'd4},     24'h1C6144, 1'b0, 1'b0);
    tbl[2] = mk({6'd11, 6'd10, 6'd9, 6'd8},   24'h2CA248, 1'b0, 1'b0);
    tbl[3] = mk({6'd15, 6'd14, 6'd13, 6'd12}, 24'h3CE34C, 1'b0, 1'b1);
    tbl[4] = mk({6'd3, 6'd2, 6'd1, 6'd0},     24'h0C2040, 1'b1, 1'b0);
    tbl[5] = mk({6'd7, 6'd6, 6'd5, 6'd4},     24'h1C6144, 1'b0, 1'b0);
    tbl[6] = mk({6'd11, 6'd10, 6'd9, 6'd8},   24'h2CA248, 1'b0, 1'b0);
    tbl[7] = mk({6'd15, 6'd14, 6'd13, 6'd12}, 24'h3CE34C, 1'b0, 1'b1);
    // Saturation codeword: first word carries -32, 31, -31, 0
`ifdef LDPC_FETCH_SAT_EN
    tbl[8] = mk({6'h00, 6'h21, 6'h1F, 6'h20}, {6'h00, 6'h21, 6'h1F, 6'h21}, 1'b1, 1'b0);
`else
    tbl[8] = mk({6'h00, 6'h21, 6'h1F, 6'h20}, {6'h00, 6'h21, 6'h1F, 6'h20}, 1'b1, 1'b0);
`endif
    tbl[9]  = mk({6'd7, 6'd6, 6'd5, 6'd4},     24'h1C6144, 1'b0, 1'b0);
    tbl[10] = mk({6'd11, 6'd10, 6'd9, 6'd8},   24'h2CA248, 1'b0, 1'b0);
    tbl[11] = mk({6'd15, 6'd14, 6'd13, 6'd12}, 24'h3CE34C, 1'b0, 1'b1);

    // Reset state
    #1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_ctrl", 32'({ldpc_req, ldpc_fin, dec_vld, dec_sop, dec_eop, ovf_err}), 32'd0);
    chk("reset_data", 32'(dec_data), 32'd0);
    rst = 1'b0;
    tick();

    // Two-codeword frame, back-to-back strobes
    clear_log();
    cw_num = 6'd2;
    dec_rdy = 1'b1;
    bidin_rdy = 1'b1;
    wait_req("frame_req0", 20);
    bidin_rdy = 1'b0;
    send_cw(0, 0);
    wait_req("frame_req1", 20);
    send_cw(4, 0);
    wait_fin("frame_fin", 20);
    repeat (5) tick();
    chk("frame_req_count", 32'(req_cnt), 32'd2);
    chk("frame_fin_count", 32'(fin_cnt), 32'd1);
    chk("frame_fin_after_eop", 32'(fin_cyc > eop_cyc), 32'd1);
    chk("frame_no_ovf", 32'(ovf_err), 32'd0);
    check_words("frame", 0, 8);

    // Flow control: dec_rdy low for 50 cycles after the first codeword
    clear_log();
    cw_num = 6'd2;
    dec_rdy = 1'b1;
    bidin_rdy = 1'b1;
    wait_req("flow_req0", 20);
    bidin_rdy = 1'b0;
    dec_rdy = 1'b0;
    send_cw(0, 0);
    repeat (50) tick();
    chk("flow_no_early_req", 32'(req_cnt), 32'd1);
    dec_rdy = 1'b1;
    tick();
    chk("flow_req_1cyc", 32'(ldpc_req), 32'd1);
    send_cw(4, 0);
    wait_fin("flow_fin", 20);
    repeat (3) tick();
    check_words("flow", 0, 8);

    // Gapped input: one strobe every 3rd cycle
    clear_log();
    cw_num = 6'd1;
    bidin_rdy = 1'b1;
    wait_req("gap_req", 20);
    bidin_rdy = 1'b0;
    send_cw(0, 2);
    wait_fin("gap_fin", 20);
    repeat (3) tick();
    check_words("gap", 0, 4);
    for (int w = 0; w < 4 && w < vq_cyc.size(); w++)
      chk($sformatf("gap_latency%0d", w), 32'(vq_cyc[w] - strobe_cyc[w]), 32'd1);

    // Overflow: stray strobe while waiting for the decoder
    clear_log();
    cw_num = 6'd1;
    dec_rdy = 1'b0;
    bidin_rdy = 1'b1;
    tick();
    tick();
    bidin_rdy = 1'b0;
    bidin_dout = 6'h2A;
    bidin_ena_out = 1'b1;
    tick();
    bidin_ena_out = 1'b0;
    tick();
    chk("ovf_set", 32'(ovf_err), 32'd1);
    dec_rdy = 1'b1;
    wait_req("ovf_req", 20);
    send_cw(0, 0);
    wait_fin("ovf_fin", 20);
    repeat (3) tick();
    check_words("ovf", 0, 4);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_req_count", 32'(req_cnt), 32'd1);

    // Saturation of the most negative soft value
    clear_log();
    cw_num = 6'd1;
    bidin_rdy = 1'b1;
    wait_req("sat_req", 20);
    bidin_rdy = 1'b0;
    send_cw(8, 0);
    wait_fin("sat_fin", 20);
    repeat (3) tick();
    check_words("sat", 8, 4);

    // Reset in the middle of a codeword, landing on a word-completing strobe
    clear_log();
    cw_num = 6'd2;
    dec_rdy = 1'b1;
    bidin_rdy = 1'b1;
    wait_req("rst_req0", 20);
    bidin_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bidin_dout = 6'(i);
      bidin_ena_out = 1'b1;
      tick();
    end
    bidin_dout = 6'd7;
    rst = 1'b1;
    tick();
    bidin_ena_out = 1'b0;
    chk("rst_mid_ctrl", 32'({ldpc_req, ldpc_fin, dec_vld, dec_sop, dec_eop, ovf_err}), 32'd0);
    chk("rst_mid_data", 32'(dec_data), 32'd0);
    rst = 1'b0;
    tick();
    clear_log();
    bidin_rdy = 1'b1;
    wait_req("rst_fresh_req", 20);
    bidin_rdy = 1'b0;
    chk("rst_no_fin", 32'(fin_cnt), 32'd0);
    send_cw(0, 0);
    wait_req("rst_req1", 20);
    send_cw(4, 0);
    wait_fin("rst_fin", 20);
    repeat (3) tick();
    check_words("rst", 0, 8);

    chk("req_fin_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
